param_commit_ctrl: RTL
======================

# param_commit_ctrl

Frame-synchronous parameter commit controller between the UART input assembler and the live scene register file that feeds the vertex-shader stage. It double-buffers the 61-byte scene packet and accepts only complete packets. It replays a committed packet into the live registers as a byte stream during vertical blank, then pulses the shader start. This keeps live geometry stable across every visible frame.

## Interface
Parameters:
- NUM_BYTES, 61, packet length in bytes (indices 0..NUM_BYTES-1)
- IDX_W, 6, index width
- COMMIT_LINE, 480, VGA line at which a pending packet is committed

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  reset; asynchronous, active-low
- wr_en  in  1  byte-write strobe from the assembler (1 cycle)
- wr_idx  in  IDX_W  byte index of the write
- wr_data  in  8  byte value
- pkt_done  in  1  end-of-packet pulse from the assembler
- vga_x  in  10  current pixel column
- vga_y  in  10  current line
- out_we  out  1  live-register byte write strobe
- out_idx  out  IDX_W  live-register byte index
- out_data  out  8  live-register byte value
- data_ready  out  1  one-cycle shader start pulse, issued after the last replayed byte
- pending  out  1  a complete packet is waiting for commit
- err_incomplete  out  1  sticky: a pkt_done arrived with bytes missing
- drop_cnt  out  8  saturating count of discarded packets and bytes

## Operation
- Storage: two banks of NUM_BYTES×8 flops. Writer pointer wb (0/1). Per-writer-bank written mask, NUM_BYTES bits.
- Write: on wr_en with wr_idx < NUM_BYTES and no deferred flip, store into bank wb and set mask[wr_idx]. wr_idx ≥ NUM_BYTES is ignored and not counted.
- pkt_done with mask all-ones is a complete packet:
  - In IDLE: bank wb becomes pending bank pb; wb flips; mask clears; go to PENDING.
  - In PENDING: the old pb is discarded (drop_cnt+1); the new bank becomes pb; wb takes the old pb; mask clears.
  - In COPY: set defer. At COPY end, wb becomes pb, wb flips, mask clears, and the FSM goes to PENDING instead of IDLE. wr_en while defer=1 is discarded (drop_cnt+1).
- pkt_done with an incomplete mask: set err_incomplete, clear mask, keep wb, no state change.
- FSM states:
  - IDLE: pending=0.
  - PENDING: pending=1.
  - COPY: read bank pb; 6-bit counter c runs 0..NUM_BYTES-1.
  - START: one cycle; data_ready=1.
- Transitions:
  - PENDING→COPY on the commit event, defined as vga_y==COMMIT_LINE && vga_x==0, sampled in the current cycle.
  - COPY→START after c = NUM_BYTES-1 is issued.
  - START→IDLE, or START→PENDING when defer was set.
- Replay: out_we=1, out_idx=c, out_data=bank[pb][c], all registered. Ascending order, no gaps.
- drop_cnt saturates at 255. err_incomplete clears only on reset.
- Simultaneous wr_en and pkt_done in the same cycle: the write is applied first, then the completeness check includes it.

## Timing
- Reset values: all outputs 0, wb=0, masks 0, defer=0, FSM IDLE. Bank contents are don't-care.
- Reset is asynchronous and aborts any replay immediately. The live registers keep whatever subset was already written.
- Commit event at cycle T:
  - out_we high for cycles T+1..T+NUM_BYTES, with out_idx 0..NUM_BYTES-1.
  - data_ready high at cycle T+NUM_BYTES+1.
  - pending falls at T+1.
- pending rises the cycle after the accepting pkt_done.
- A commit event in IDLE or COPY is ignored. A packet completing after line COMMIT_LINE, column 0 waits one full frame.
- At most one commit per frame.

## Test plan
- Complete packet, bytes 0..60 with value idx+1, then pkt_done while vga_y=100 → pending=1; at y=480,x=0 the bench sees 61 out_we cycles with out_data 1..61, then data_ready one cycle later; pending=0.
- pkt_done after only bytes 0..59 → err_incomplete=1, pending stays 0, no replay at line 480. A following full packet commits normally.
- Two complete packets before line 480 (first all 0xAA, second all 0x55) → drop_cnt=1; replay outputs 0x55 only.
- pkt_done during COPY, then wr_en during defer → replay of the first packet completes unchanged; drop_cnt=1; pending=1 after START; the second packet is replayed next frame.
- wr_idx=63 write → no mask or data change. wr_en and pkt_done for byte 60 in the same cycle → packet accepted.
- rst_n low at replay byte 20 → out_we drops asynchronously, all outputs 0, FSM IDLE; no data_ready.

Source files
------------

// File: rtl/param_commit_ctrl.sv
// Double-buffered scene-packet commit controller.
// Replays a committed packet into live registers during vertical blank.
module param_commit_ctrl #(
    parameter int NUM_BYTES   = 61,
    parameter int IDX_W       = 6,
    parameter int COMMIT_LINE = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    input  logic             pkt_done,
    input  logic [9:0]       vga_x,
    input  logic [9:0]       vga_y,
    output logic             out_we,
    output logic [IDX_W-1:0] out_idx,
    output logic [7:0]       out_data,
    output logic             data_ready,
    output logic             pending,
    output logic             err_incomplete,
    output logic [7:0]       drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_COPY,
        S_START
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BYTES - 1);

    logic [7:0]           bank_q [2][NUM_BYTES];
    state_t               state_q, state_d;
    logic                 wb_q, wb_d;
    logic                 pb_q, pb_d;
    logic [NUM_BYTES-1:0] mask_q, mask_d;
    logic                 defer_q, defer_d;
    logic                 err_q, err_d;
    logic [7:0]           drop_q, drop_d;
    logic [IDX_W-1:0]     c_q, c_d;
    logic                 we_q, we_d;
    logic [7:0]           data_q, data_d;

    logic                 commit;
    logic                 wr_hit;
    logic                 wr_ok;
    logic [NUM_BYTES-1:0] mask_wr;
    logic                 complete;
    logic                 busy;
    logic [1:0]           drop_inc;
    logic [8:0]           drop_sum;

    assign commit  = (vga_y == 10'(COMMIT_LINE)) && (vga_x == 10'd0);
    assign wr_hit  = wr_en && (wr_idx < IDX_W'(NUM_BYTES));
    assign wr_ok   = wr_hit && !defer_q;
    assign mask_wr = wr_ok ? (mask_q | (NUM_BYTES'(1) << wr_idx)) : mask_q;
    assign complete = &mask_wr;
    // A commit taken this cycle makes the packet slot behave as if copying.
    assign busy = (state_q == S_COPY) ||
                  ((state_q == S_PENDING) && commit);

    // Packet banks: written by the assembler into the writer bank.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            bank_q[wb_q][wr_idx] <= wr_data;
        end
    end

    // Next-state: replay sequencing, then packet acceptance on pkt_done.
    always_comb begin
        state_d  = state_q;
        wb_d     = wb_q;
        pb_d     = pb_q;
        mask_d   = mask_wr;
        defer_d  = defer_q;
        err_d    = err_q;
        c_d      = c_q;
        we_d     = 1'b0;
        drop_inc = 2'd0;

        if (wr_hit && defer_q) begin
            drop_inc = drop_inc + 2'd1;
        end

        unique case (state_q)
            S_IDLE: begin
            end
            S_PENDING: begin
                if (commit) begin
                    state_d = S_COPY;
                    c_d     = '0;
                    we_d    = 1'b1;
                end
            end
            S_COPY: begin
                if (c_q == LAST) begin
                    state_d = S_START;
                end else begin
                    c_d  = IDX_W'(c_q + 1'b1);
                    we_d = 1'b1;
                end
            end
            S_START: begin
                state_d = S_IDLE;
                if (defer_q) begin
                    state_d = S_PENDING;
                    pb_d    = wb_q;
                    wb_d    = ~wb_q;
                    mask_d  = '0;
                    defer_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pkt_done) begin
            if (defer_q) begin
                drop_inc = drop_inc + 2'd1;
            end else if (!complete) begin
                err_d  = 1'b1;
                mask_d = '0;
            end else if (busy) begin
                defer_d = 1'b1;
            end else begin
                if (state_q == S_PENDING) begin
                    drop_inc = drop_inc + 2'd1;
                end
                pb_d    = wb_q;
                wb_d    = ~wb_q;
                mask_d  = '0;
                state_d = S_PENDING;
            end
        end

        data_d   = we_d ? bank_q[pb_q][c_d] : data_q;
        drop_sum = {1'b0, drop_q} + {7'd0, drop_inc};
        drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // State and output registers; reset aborts any replay at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wb_q    <= 1'b0;
            pb_q    <= 1'b0;
            mask_q  <= '0;
            defer_q <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 8'd0;
            c_q     <= '0;
            we_q    <= 1'b0;
            data_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            wb_q    <= wb_d;
            pb_q    <= pb_d;
            mask_q  <= mask_d;
            defer_q <= defer_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            c_q     <= c_d;
            we_q    <= we_d;
            data_q  <= data_d;
        end
    end

    assign out_we         = we_q;
    assign out_idx        = c_q;
    assign out_data       = data_q;
    assign data_ready     = (state_q == S_START);
    assign pending        = (state_q == S_PENDING);
    assign err_incomplete = err_q;
    assign drop_cnt       = drop_q;

endmodule
